// File: rtl/tetris_pkg.sv
// Shared game-phase encoding for the Tetris chip; the datapath decoders
// (spawner, gravity/move, line clearer, display) import these too.
package tetris_pkg;

   typedef enum logic [2:0] {
      RESET = 3'd0,
      SPAWN = 3'd1,
      FALL  = 3'd2,
      CLEAR = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam int unsigned STATE_W = 3;

endpackage

// File: rtl/main_fsm.sv
// Top-level game-control sequencer: reset, spawn, fall, line clear and
// game over, advanced by the placed / game_over flags from the board logic.
//
//   state | meaning
//   ------+--------------------------------------------------
//   RESET | restart held or just released
//   SPAWN | spawner drops a new piece onto the board
//   FALL  | gravity/move logic owns the active piece
//   CLEAR | line clearer removes completed rows
//   OVER  | board overflowed; waits for restart
module main_fsm
   import tetris_pkg::*;
(
   input  logic                in_clka,
   input  logic                in_clkb,
   input  logic                restart,
   input  logic                placed,
   input  logic                game_over,
   output logic [STATE_W-1:0]  state
);

   state_t state_q;
   state_t state_d;

   // The second clock phase only exists to keep the chip-level port list intact.
   logic unused_clkb;
   assign unused_clkb = in_clkb;

   always_comb begin
      state_d = RESET;
      case (state_q)
         RESET: state_d = SPAWN;
         SPAWN: state_d = game_over ? OVER : FALL;
         FALL: begin
            if (game_over)
               state_d = OVER;
            else if (placed)
               state_d = CLEAR;
            else
               state_d = FALL;
         end
         CLEAR: state_d = game_over ? OVER : SPAWN;
         OVER:  state_d = OVER;
         default: state_d = RESET;
      endcase
   end

   always_ff @(posedge in_clka or posedge restart) begin
      if (restart)
         state_q <= RESET;
      else
         state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: hand-computed state after each in_clka edge.
module tb_main_fsm;
   import tetris_pkg::*;

   logic       in_clka = 1'b0;
   logic       in_clkb;
   logic       restart;
   logic       placed;
   logic       game_over;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   main_fsm dut (
      .in_clka   (in_clka),
      .in_clkb   (in_clkb),
      .restart   (restart),
      .placed    (placed),
      .game_over (game_over),
      .state     (state)
   );

   always #5 in_clka = ~in_clka;
   assign in_clkb = ~in_clka;

   task automatic check(input string tag, input logic [2:0] exp);
      checks++;
      assert (state === exp) else begin
         errors++;
         $error("FAIL %s: state observed %0d expected %0d", tag, state, exp);
      end
   endtask

   // Inputs change while in_clka is low; state is sampled 1 time unit after the edge.
   task automatic step(input logic r, input logic p, input logic g);
      @(negedge in_clka);
      restart   = r;
      placed    = p;
      game_over = g;
      @(posedge in_clka);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      restart = 1'b1; placed = 1'b0; game_over = 1'b0;
      #1;
      check("reset_async_powerup", 3'd0);
      @(posedge in_clka); #1;
      check("reset_held_edge", 3'd0);

      // reset sequence
      step(0, 0, 0); check("rst_to_spawn", 3'd1);
      step(0, 0, 0); check("spawn_to_fall", 3'd2);
      step(0, 0, 0); check("fall_hold_1", 3'd2);
      step(0, 0, 0); check("fall_hold_2", 3'd2);

      // single-cycle placement loop
      step(0, 1, 0); check("fall_to_clear", 3'd3);
      step(0, 0, 0); check("clear_to_spawn", 3'd1);
      step(0, 0, 0); check("spawn_to_fall_2", 3'd2);

      // placed held high: exactly one FALL->CLEAR, ignored in CLEAR and SPAWN
      step(0, 1, 0); check("held_fall_to_clear", 3'd3);
      step(0, 1, 0); check("held_clear_to_spawn", 3'd1);
      step(0, 1, 0); check("held_spawn_to_fall", 3'd2);
      step(0, 1, 0); check("held_fall_to_clear_2", 3'd3);
      step(0, 0, 0); check("clear_to_spawn_2", 3'd1);
      step(0, 0, 0); check("spawn_to_fall_3", 3'd2);

      // game_over beats placed in FALL; OVER is sticky
      step(0, 1, 1); check("prio_fall_over", 3'd4);
      step(0, 0, 0); check("over_hold_1", 3'd4);
      step(0, 0, 0); check("over_hold_2", 3'd4);
      step(0, 0, 0); check("over_hold_3", 3'd4);
      step(0, 1, 0); check("over_ignores_placed", 3'd4);

      // async restart between edges while in OVER
      @(negedge in_clka);
      placed = 1'b0; restart = 1'b1;
      #1;
      check("async_rst_over", 3'd0);
      @(posedge in_clka); #1;
      check("async_rst_held", 3'd0);
      step(0, 0, 0); check("rst_release_spawn", 3'd1);

      // game_over in SPAWN
      step(0, 0, 1); check("spawn_to_over", 3'd4);

      // game_over in CLEAR
      step(1, 0, 0); check("restart_sync_view", 3'd0);
      step(0, 0, 0); check("rst_release_spawn_2", 3'd1);
      step(0, 0, 0); check("spawn_to_fall_4", 3'd2);
      step(0, 1, 0); check("fall_to_clear_3", 3'd3);
      step(0, 0, 1); check("clear_to_over", 3'd4);

      // async restart between edges while in FALL
      step(1, 0, 0); check("restart_again", 3'd0);
      step(0, 0, 0); check("spawn_after_rst", 3'd1);
      step(0, 0, 0); check("fall_after_rst", 3'd2);
      @(negedge in_clka);
      restart = 1'b1;
      #1;
      check("async_rst_fall", 3'd0);
      step(0, 0, 0); check("rst_release_spawn_3", 3'd1);
      step(0, 0, 0); check("spawn_to_fall_5", 3'd2);

      // illegal-state recovery
      @(negedge in_clka);
      force dut.state_q = state_t'(3'd6);
      #1;
      check("forced_illegal", 3'd6);
      release dut.state_q;
      @(posedge in_clka); #1;
      check("illegal_to_reset", 3'd0);
      step(0, 0, 0); check("recover_spawn", 3'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
